imem_access_ctrl: RTL

//  Owns the single port of the instruction memory and shares it between the CPU fetch path and a byte-stream program loader.

---
 rtl/imem_ctrl_pkg.sv | 14 +
 rtl/imem_byte_packer.sv | 56 +++++
 rtl/imem_access_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int          ADDR_LSB = 2;
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream little-endian into N-bit words; a word is complete after
// its top lane or on the last byte, with unfilled lanes left at zero.
module imem_byte_packer #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_clear,
    input  logic         i_valid,
    input  logic [7:0]   i_byte,
    input  logic         i_last,
    input  logic         i_ready,
    output logic         o_word_valid,
    output logic [N-1:0] o_word,
    output logic         o_last_seen
);

    localparam int LANES  = N / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0] r_lane;
    logic [N-1:0]      r_word;
    logic              r_last;
    logic              w_accept;
    logic              w_final;

    assign w_accept = i_valid & i_ready;
    assign w_final  = (r_lane == TOP_LANE) | i_last;

    // Lane 0 rewrites the whole word so a short final word is zero-padded.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_lane <= '0;
            r_word <= '0;
            r_last <= 1'b0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_word <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            if (r_lane == '0) begin
                r_word <= {{(N-8){1'b0}}, i_byte};
            end else begin
                r_word[8*r_lane +: 8] <= i_byte;
            end
            r_lane <= w_final ? '0 : r_lane + 1'b1;
            r_last <= r_last | i_last;
        end
    end

    assign o_word_valid = w_accept & w_final;
    assign o_word       = r_word;
    assign o_last_seen  = r_last;

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the instruction-memory port between CPU fetch and a byte-stream loader.
// Optional IMEM_BOUNDS_CHECK_EN: out-of-range fetches return a NOP and flag a fault.
module imem_access_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int N       = 32,
    parameter int DEPTH   = 76,
    localparam int INDEX_W = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_fetch_req,
    input  logic [N-1:0]       i_fetch_addr,
    output logic               o_fetch_valid,
    output logic [N-1:0]       o_fetch_inst,
    output logic               o_fetch_stall,
    output logic               o_fetch_fault,
    input  logic               i_ld_start,
    input  logic               i_ld_valid,
    input  logic [7:0]         i_ld_byte,
    input  logic               i_ld_last,
    output logic               o_ld_ready,
    output logic               o_ld_done,
    output logic               o_cpu_hold,
    output logic [INDEX_W-1:0] o_mem_addr,
    output logic               o_mem_we,
    output logic [N-1:0]       o_mem_wdata,
    input  logic [N-1:0]       i_mem_rdata
);

    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

    state_t             r_state;
    logic [INDEX_W-1:0] r_ptr;
    logic               r_fetch_valid;
    logic               r_fetch_oob;

    logic [INDEX_W-1:0] w_index;
    logic               w_in_run;
    logic               w_start;
    logic               w_grant;
    logic               w_oob;
    logic               w_read;
    logic               w_word_valid;
    logic [N-1:0]       w_word;
    logic               w_last_seen;
    logic               w_unused_addr;

    assign w_index       = i_fetch_addr[ADDR_LSB +: INDEX_W];
    assign w_unused_addr = ^{i_fetch_addr[N-1:ADDR_LSB+INDEX_W], i_fetch_addr[ADDR_LSB-1:0]};
    assign w_in_run      = (r_state == S_RUN);
    assign w_start       = w_in_run & i_ld_start;
    assign w_grant       = w_in_run & i_fetch_req & ~i_ld_start;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign w_oob = (w_index > LAST_IDX);
`else
    assign w_oob = 1'b0;
`endif

    assign w_read = w_grant & ~w_oob;

    imem_byte_packer #(.N(N)) u_packer (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_clear      (w_start),
        .i_valid      (i_ld_valid),
        .i_byte       (i_ld_byte),
        .i_last       (i_ld_last),
        .i_ready      (o_ld_ready),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_last_seen  (w_last_seen)
    );

    // Load sequencing plus the one-cycle fetch response pipeline.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state       <= S_RUN;
            r_ptr         <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_oob   <= 1'b0;
        end else begin
            r_fetch_valid <= w_grant;
            r_fetch_oob   <= w_grant & w_oob;
            case (r_state)
                S_RUN: begin
                    if (i_ld_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_word_valid) r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_state <= (w_last_seen || r_ptr == LAST_IDX) ? S_DONE : S_LOAD;
                end
                S_DONE:  r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign o_ld_ready    = (r_state == S_LOAD);
    assign o_mem_we      = (r_state == S_WRITE);
    assign o_ld_done     = (r_state == S_DONE);
    assign o_cpu_hold    = ~w_in_run;
    assign o_fetch_stall = ~w_in_run | i_ld_start;
    assign o_mem_addr    = o_mem_we ? r_ptr : (w_read ? w_index : '0);
    assign o_mem_wdata   = w_word;
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_fault = r_fetch_oob;
    assign o_fetch_inst  = !r_fetch_valid ? '0 : (r_fetch_oob ? N'(NOP_INST) : i_mem_rdata);

endmodule
